// File: rtl/rv32i_types.sv
// Shared RV32I types: opcodes, funct3 codes, ALU operations and the
// control word that travels down the pipeline.
package rv32i_types;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0060;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } opcode_t;

  typedef enum logic [2:0] {
    f3_beq  = 3'b000,
    f3_bne  = 3'b001,
    f3_blt  = 3'b100,
    f3_bge  = 3'b101,
    f3_bltu = 3'b110,
    f3_bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } arith_funct3_t;

  typedef enum logic [3:0] {
    alu_add, alu_sub, alu_sll, alu_slt, alu_sltu, alu_xor,
    alu_srl, alu_sra, alu_or, alu_and, alu_passb
  } alu_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    alu_op_t     aluop;
    logic        op1_pc;
    logic        op2_imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jal;
    logic        jalr;
  } ctrl_t;

  // bit 30 selects SUB (register form only) and SRA/SRAI
  function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
    alu_op_t op;
    case (f3)
      f3_add:  op = (is_reg && alt) ? alu_sub : alu_add;
      f3_sll:  op = alu_sll;
      f3_slt:  op = alu_slt;
      f3_sltu: op = alu_sltu;
      f3_xor:  op = alu_xor;
      f3_sr:   op = alt ? alu_sra : alu_srl;
      f3_or:   op = alu_or;
      f3_and:  op = alu_and;
      default: op = alu_add;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mp3_datapath.sv
// Five-stage pipeline: decode in ID, branch/jump resolution and forwarding in EX,
// single-cycle memories in IF and MEM.
module mp3_datapath
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icache_address,
  input  logic [31:0] icache_rdata,
  output logic [31:0] dcache_address,
  input  logic [31:0] dcache_rdata,
  output logic        dcache_read,
  output logic        dcache_write,
  output logic [31:0] dcache_wdata
);

  logic [31:0] pc, pcmux_out, pipereg_exmem_pc_out;
  logic [31:0] ifid_pc, ifid_instr;
  ctrl_t       idex_ctrl;
  logic [31:0] idex_rs1v, idex_rs2v;
  logic [31:0] exmem_pc, exmem_result, exmem_wdata;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regwrite, exmem_memread, exmem_memwrite, memwb_regwrite;
  logic [31:0] memwb_result;
  logic [31:0] rf_rs1, rf_rs2, fwd_a, fwd_b, op_a, op_b, alu_out;
  logic [31:0] target, ex_result, mem_result;
  logic        cond, taken, stall;

  function automatic ctrl_t decode(input logic [31:0] i, input logic [31:0] ipc);
    ctrl_t c;
    c = '0;
    c.pc = ipc;
    c.rs1 = i[19:15];
    c.rs2 = i[24:20];
    c.rd = i[11:7];
    c.funct3 = i[14:12];
    c.aluop = alu_add;
    case (i[6:0])
      op_lui:   begin c.imm = {i[31:12], 12'h000}; c.op2_imm = 1'b1; c.aluop = alu_passb; c.regwrite = 1'b1; end
      op_auipc: begin c.imm = {i[31:12], 12'h000}; c.op1_pc = 1'b1; c.op2_imm = 1'b1; c.regwrite = 1'b1; end
      op_jal:   begin c.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; c.jal = 1'b1; c.regwrite = 1'b1; end
      op_jalr:  begin c.imm = {{20{i[31]}}, i[31:20]}; c.jalr = 1'b1; c.regwrite = 1'b1; end
      op_br:    begin c.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; c.branch = 1'b1; end
      op_load:  if (i[14:12] == 3'b010) begin
                  c.imm = {{20{i[31]}}, i[31:20]}; c.op2_imm = 1'b1; c.memread = 1'b1; c.regwrite = 1'b1;
                end
      op_store: if (i[14:12] == 3'b010) begin
                  c.imm = {{20{i[31]}}, i[31:25], i[11:7]}; c.op2_imm = 1'b1; c.memwrite = 1'b1;
                end
      op_imm:   begin c.imm = {{20{i[31]}}, i[31:20]}; c.op2_imm = 1'b1; c.regwrite = 1'b1;
                  c.aluop = alu_sel(i[14:12], i[30], 1'b0); end
      op_reg:   begin c.regwrite = 1'b1; c.aluop = alu_sel(i[14:12], i[30], 1'b1); end
      default:  c.regwrite = 1'b0;
    endcase
    // x0 destinations carry no write so the NOP encoding decodes to a true bubble
    if (c.rd == 5'd0) begin
      c.regwrite = 1'b0;
      c.memread = 1'b0;
    end
    return c;
  endfunction

  // Flushed slots carry the redirect target, so a self-jump makes exmem pc equal pcmux
  function automatic ctrl_t bubble(input logic [31:0] p);
    ctrl_t c;
    c = '0;
    c.pc = p;
    return c;
  endfunction

  mp3_regfile regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (memwb_regwrite),
    .waddr  (memwb_rd),
    .wdata  (memwb_result),
    .raddr1 (ifid_instr[19:15]),
    .raddr2 (ifid_instr[24:20]),
    .rdata1 (rf_rs1),
    .rdata2 (rf_rs2)
  );

  // EX operand forwarding, EX/MEM over MEM/WB
  always_comb begin
    if (exmem_regwrite && (exmem_rd == idex_ctrl.rs1)) fwd_a = exmem_result;
    else if (memwb_regwrite && (memwb_rd == idex_ctrl.rs1)) fwd_a = memwb_result;
    else fwd_a = idex_rs1v;
    if (exmem_regwrite && (exmem_rd == idex_ctrl.rs2)) fwd_b = exmem_result;
    else if (memwb_regwrite && (memwb_rd == idex_ctrl.rs2)) fwd_b = memwb_result;
    else fwd_b = idex_rs2v;
  end

  assign op_a = idex_ctrl.op1_pc ? idex_ctrl.pc : fwd_a;
  assign op_b = idex_ctrl.op2_imm ? idex_ctrl.imm : fwd_b;

  // ALU
  always_comb begin
    case (idex_ctrl.aluop)
      alu_add:   alu_out = op_a + op_b;
      alu_sub:   alu_out = op_a - op_b;
      alu_sll:   alu_out = op_a << op_b[4:0];
      alu_slt:   alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
      alu_sltu:  alu_out = {31'd0, op_a < op_b};
      alu_xor:   alu_out = op_a ^ op_b;
      alu_srl:   alu_out = op_a >> op_b[4:0];
      alu_sra:   alu_out = $signed(op_a) >>> op_b[4:0];
      alu_or:    alu_out = op_a | op_b;
      alu_and:   alu_out = op_a & op_b;
      alu_passb: alu_out = op_b;
      default:   alu_out = op_a + op_b;
    endcase
  end

  // Branch condition on forwarded operands
  always_comb begin
    case (idex_ctrl.funct3)
      f3_beq:  cond = (fwd_a == fwd_b);
      f3_bne:  cond = (fwd_a != fwd_b);
      f3_blt:  cond = ($signed(fwd_a) < $signed(fwd_b));
      f3_bge:  cond = ($signed(fwd_a) >= $signed(fwd_b));
      f3_bltu: cond = (fwd_a < fwd_b);
      f3_bgeu: cond = (fwd_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign taken = idex_ctrl.jal | idex_ctrl.jalr | (idex_ctrl.branch & cond);
  assign target = idex_ctrl.jalr ? ((fwd_a + idex_ctrl.imm) & ~32'd1) : (idex_ctrl.pc + idex_ctrl.imm);
  assign ex_result = (idex_ctrl.jal | idex_ctrl.jalr) ? (idex_ctrl.pc + 32'd4) : alu_out;
  assign stall = idex_ctrl.memread &&
                 ((idex_ctrl.rd == ifid_instr[19:15]) || (idex_ctrl.rd == ifid_instr[24:20]));
  assign pcmux_out = taken ? target : (stall ? pc : pc + 32'd4);

  assign icache_address = pc;
  assign dcache_address = {exmem_result[31:2], 2'b00};
  assign dcache_read = exmem_memread;
  assign dcache_write = exmem_memwrite;
  assign dcache_wdata = exmem_wdata;
  assign mem_result = exmem_memread ? dcache_rdata : exmem_result;
  assign pipereg_exmem_pc_out = exmem_pc;

  // Pipeline registers; a taken redirect overrides a concurrent load-use stall
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
      ifid_pc <= 32'd0;
      ifid_instr <= NOP;
      idex_ctrl <= '0;
      idex_rs1v <= 32'd0;
      idex_rs2v <= 32'd0;
      exmem_pc <= 32'd0;
      exmem_result <= 32'd0;
      exmem_wdata <= 32'd0;
      exmem_rd <= 5'd0;
      exmem_regwrite <= 1'b0;
      exmem_memread <= 1'b0;
      exmem_memwrite <= 1'b0;
      memwb_rd <= 5'd0;
      memwb_regwrite <= 1'b0;
      memwb_result <= 32'd0;
    end else begin
      pc <= pcmux_out;
      if (taken) begin
        ifid_pc <= target;
        ifid_instr <= NOP;
        idex_ctrl <= bubble(target);
        idex_rs1v <= 32'd0;
        idex_rs2v <= 32'd0;
      end else if (stall) begin
        idex_ctrl <= '0;
        idex_rs1v <= 32'd0;
        idex_rs2v <= 32'd0;
      end else begin
        ifid_pc <= pc;
        ifid_instr <= icache_rdata;
        idex_ctrl <= decode(ifid_instr, ifid_pc);
        idex_rs1v <= rf_rs1;
        idex_rs2v <= rf_rs2;
      end
      exmem_pc <= idex_ctrl.pc;
      exmem_result <= ex_result;
      exmem_wdata <= fwd_b;
      exmem_rd <= idex_ctrl.rd;
      exmem_regwrite <= idex_ctrl.regwrite;
      exmem_memread <= idex_ctrl.memread;
      exmem_memwrite <= idex_ctrl.memwrite;
      memwb_rd <= exmem_rd;
      memwb_regwrite <= exmem_regwrite;
      memwb_result <= mem_result;
    end
  end

endmodule

// File: rtl/mp3_regfile.sv
// 32x32 register file, x0 hard-wired to zero, write-through to same-cycle reads.
module mp3_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] data [32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) data[i] <= 32'd0;
    end else if (we && (waddr != 5'd0)) begin
      data[waddr] <= wdata;
    end else begin
      data[0] <= 32'd0;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 :
                  (we && (waddr == raddr1)) ? wdata : data[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 :
                  (we && (waddr == raddr2)) ? wdata : data[raddr2];

endmodule

// File: rtl/mp3.sv
// RV32I five-stage core top: wires the datapath to split instruction/data memory ports.
module mp3
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icache_address,
  input  logic [31:0] icache_rdata,
  output logic        icache_read,
  output logic        icache_write,
  output logic [31:0] icache_wdata,
  output logic [31:0] dcache_address,
  input  logic [31:0] dcache_rdata,
  output logic        dcache_read,
  output logic        dcache_write,
  output logic [31:0] dcache_wdata
);

  assign icache_read = 1'b1;
  assign icache_write = 1'b0;
  assign icache_wdata = 32'd0;

  mp3_datapath d (
    .clk            (clk),
    .rst            (rst),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .dcache_address (dcache_address),
    .dcache_rdata   (dcache_rdata),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_wdata   (dcache_wdata)
  );

endmodule

// File: tb/tb_mp3.sv
// Directed bench for mp3: magic memories, hand-computed register/fetch/store expectations.
module tb_mp3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] icache_address, icache_rdata, icache_wdata;
  logic        icache_read, icache_write;
  logic [31:0] dcache_address, dcache_rdata, dcache_wdata;
  logic        dcache_read, dcache_write;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mp3 dut (
    .clk            (clk),
    .rst            (rst),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_read    (icache_read),
    .icache_write   (icache_write),
    .icache_wdata   (icache_wdata),
    .dcache_address (dcache_address),
    .dcache_rdata   (dcache_rdata),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_wdata   (dcache_wdata)
  );

  assign icache_rdata = imem[icache_address[11:2]];
  assign dcache_rdata = dmem[dcache_address[11:2]];

  always @(posedge clk) begin
    if (dcache_write) dmem[dcache_address[11:2]] <= dcache_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.d.regfile.data[i];
  endfunction

  function automatic logic [31:0] rf_or();
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < 32; i++) acc = acc | rf(i);
    return acc;
  endfunction

  logic [31:0] fetch [24];
  logic [31:0] exp_regs [8];
  logic [31:0] wr_addr, wr_data, halt_pc;
  int writes, reads, wr_cyc, rd_cyc, halt_cycle;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 32'h0000_0013;
      dmem[i] = 32'd0;
    end
    imem[24] = 32'h0050_0093; // 0x60 addi x1,x0,5
    imem[25] = 32'h0030_8113; // 0x64 addi x2,x1,3
    imem[26] = 32'h0020_81B3; // 0x68 add  x3,x1,x2
    imem[27] = 32'h1000_2203; // 0x6C lw   x4,0x100(x0)
    imem[28] = 32'h0012_0293; // 0x70 addi x5,x4,1
    imem[29] = 32'h0000_0463; // 0x74 beq  x0,x0,+8
    imem[30] = 32'h0010_0313; // 0x78 addi x6,x0,1 (skipped)
    imem[31] = 32'h2010_2023; // 0x7C sw   x1,0x200(x0)
    imem[32] = 32'h00C0_03EF; // 0x80 jal  x7,+12
    imem[33] = 32'h0020_0313; // 0x84 addi x6,x0,2 (skipped)
    imem[34] = 32'h0030_0313; // 0x88 addi x6,x0,3 (skipped)
    imem[35] = 32'h0000_006F; // 0x8C jal  x0,0
    dmem[64] = 32'hDEAD_BEEF;
    exp_regs = '{32'd0, 32'd5, 32'd8, 32'd13, 32'hDEAD_BEEF, 32'hDEAD_BEF0, 32'd0, 32'h84};

    rst = 1'b0;
    tick();
    tick();
    check("reset_pc", icache_address, 32'h60);
    check("reset_dread", {31'd0, dcache_read}, 32'd0);
    check("reset_dwrite", {31'd0, dcache_write}, 32'd0);
    check("reset_regs", rf_or(), 32'd0);
    check("icache_read_const", {31'd0, icache_read}, 32'd1);

    rst = 1'b1;
    writes = 0; reads = 0; wr_cyc = -1; rd_cyc = -1; halt_cycle = -1;
    wr_addr = 32'd0; wr_data = 32'd0; halt_pc = 32'd0;
    for (int k = 0; k < 24; k++) begin
      fetch[k] = icache_address;
      if (dcache_write) begin writes++; wr_cyc = k; wr_addr = dcache_address; wr_data = dcache_wdata; end
      if (dcache_read) begin reads++; rd_cyc = k; end
      if (halt_cycle < 0 && (dut.d.pipereg_exmem_pc_out === dut.d.pcmux_out)) begin
        halt_cycle = k;
        halt_pc = dut.d.pcmux_out;
      end
      tick();
    end

    check("fetch0", fetch[0], 32'h60);
    check("fetch1", fetch[1], 32'h64);
    check("fetch5_load_use", fetch[5], 32'h74);
    check("fetch6_stall_hold", fetch[6], 32'h74);
    check("fetch7_one_stall", fetch[7], 32'h78);
    check("fetch8_branch_ex", fetch[8], 32'h7C);
    check("fetch9_target", fetch[9], 32'h7C);
    check("fetch10_after_flush", fetch[10], 32'h80);
    check("fetch13_jal_target", fetch[13], 32'h8C);
    check("fetch14", fetch[14], 32'h90);
    for (int r = 0; r < 8; r++) check($sformatf("reg_x%0d", r), rf(r), exp_regs[r]);
    check("store_count", writes, 32'd1);
    check("store_cycle", wr_cyc, 32'd12);
    check("store_addr", wr_addr, 32'h200);
    check("store_data", wr_data, 32'd5);
    check("dmem_0x200", dmem[128], 32'd5);
    check("load_count", reads, 32'd1);
    check("load_cycle", rd_cyc, 32'd6);
    check("halt_cycle", halt_cycle, 32'd15);
    check("halt_pc", halt_pc, 32'h8C);

    writes = 0;
    for (int k = 0; k < 20; k++) begin
      if (dcache_write) writes++;
      tick();
    end
    for (int r = 0; r < 8; r++) check($sformatf("halted_x%0d", r), rf(r), exp_regs[r]);
    check("halted_no_store", writes, 32'd0);

    rst = 1'b0;
    tick();
    check("midreset_pc", icache_address, 32'h60);
    check("midreset_dwrite", {31'd0, dcache_write}, 32'd0);
    check("midreset_dread", {31'd0, dcache_read}, 32'd0);
    check("midreset_regs", rf_or(), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("rerun_x1", rf(1), 32'd5);
    check("rerun_x7", rf(7), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
